axi_write_slave: RTL
====================

# axi_write_slave

- AXI write-path slave that consumes the master-side write address, write data and write response channels.
- Accepts one burst at a time (AW, then W beats) and commits the strobed bytes into an internal word memory.
- Returns a single B response carrying the burst ID.
- Sits directly downstream of the testbench BFM as the DUV-side responder; a combinational debug port exposes memory contents to the scoreboard.

## Interface
Parameters:
- WIDTH, 32, data/address width; strobe, ID and LEN width is WIDTH/8
- SIZE, 3, AxSIZE width; BURST/RESP width is SIZE-1
- MEM_WORDS, 256, memory depth in WIDTH-bit words

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- AWID  in  WIDTH/8  write burst ID
- AWADDR  in  WIDTH  byte start address
- AWLEN  in  WIDTH/8  beats minus one
- AWSIZE  in  SIZE  log2 bytes per beat
- AWBURST  in  SIZE-1  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- AWVALID  in  1  address valid
- AWREADY  out  1  address accept
- WID  in  WIDTH/8  data beat ID
- WDATA  in  WIDTH  beat data
- WSTRB  in  WIDTH/8  byte lane enables
- WLAST  in  1  final beat marker
- WVALID  in  1  data valid
- WREADY  out  1  data accept
- BID  out  WIDTH/8  response ID (captured AWID)
- BRESP  out  SIZE-1  00 OKAY, 10 SLVERR
- BVALID  out  1  response valid
- BREADY  in  1  response accept
- dbg_addr  in  $clog2(MEM_WORDS)  debug word index
- dbg_data  out  WIDTH  combinational memory read at dbg_addr

## Operation
- FSM: IDLE -> DATA on AW handshake; DATA -> RESP on the handshake of beat AWLEN; RESP -> IDLE on BVALID&&BREADY.
- IDLE:
  - AWREADY=1.
  - On AW handshake capture ID, addr, len, size, burst; clear beat counter and error flag.
- DATA:
  - WREADY=1.
  - Each W handshake writes lane i of mem[addr>>2] when WSTRB[i]=1.
  - Beat counter increments; burst length is set by AWLEN alone.
- Next address:
  - FIXED: unchanged.
  - INCR: addr + (1<<size).
  - WRAP: as INCR, wrapped within an aligned window of (1<<size)*(len+1) bytes.
- Error flag set (sticky per burst) by any of:
  - AWSIZE > log2(WIDTH/8): burst consumed, no writes.
  - AWBURST=11: burst consumed, no writes.
  - WRAP with len not 1/3/7/15, or with an unaligned start: burst consumed, no writes.
  - Beat word index >= MEM_WORDS: that beat not written.
  - WID != captured AWID: beat still written.
  - WLAST value != (counter==len) on any beat.
- RESP:
  - BVALID=1, BID=captured ID.
  - BRESP=10 if error flag, else 00.
  - BVALID held until BREADY.
- Reset mid-burst: FSM to IDLE; partial writes already committed remain; memory is never cleared by reset.

## Timing
- Reset values: AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=00; FSM in IDLE; AWREADY rises the first clk after reset deasserts.
- AW handshake at edge N -> WREADY=1 from N+1; AWREADY=0 outside IDLE.
- Full throughput: one beat per cycle while WVALID is held.
- Last beat at edge M -> BVALID=1 from M+1; WREADY=0 in RESP.
- BVALID&&BREADY at edge K -> AWREADY=1 from K+1. Minimum burst-to-burst spacing: 3 cycles for a single-beat burst.
- A memory write at edge E is visible on dbg_data after E.
- AWVALID/WVALID asserted outside their accepting state are ignored (no handshake).

## Configuration
- AXI_WRAP_BURST_EN defined: WRAP bursts supported as above.
- Not defined: AWBURST=10 is treated like reserved: burst consumed, no writes, BRESP=10.

## Test plan
- Single INCR beat: AWADDR=0x10, LEN=0, SIZE=2, ID=3, WDATA=0xDEADBEEF, WSTRB=F -> dbg_addr=4 reads 0xDEADBEEF; BID=3, BRESP=00, one cycle after the beat.
- INCR 4 beats at 0x0 with data 1..4 and WSTRB=0x3 on beat 2 over prior 0xFFFFFFFF:
  - words 0..3 = 1, 0xFFFF0002, 3, 4;
  - BRESP=00.
- WRAP (macro on): ADDR=0x08, LEN=3, SIZE=2, data A,B,C,D -> words 2,3,0,1 = A,B,C,D; BRESP=00. Macro off: words unchanged, BRESP=10.
- Error checks:
  - Early WLAST on beat 0 of a LEN=1 burst -> 2 beats still accepted, BRESP=10.
  - AWSIZE=3 -> no writes, BRESP=10.
  - AWADDR=0x400 with MEM_WORDS=256 -> BRESP=10.
- BREADY held low 5 cycles: BVALID/BID stay stable and AWREADY stays 0; after BREADY=1, AWREADY=1 next cycle.
- reset low mid-burst after beat 1 of 4: outputs go to reset values immediately, beat 1 data persists, and a following burst completes with BRESP=00.

Source files
------------

// File: rtl/axi_write_slave.sv
// axi_write_slave: single-burst AXI write responder committing strobed bytes to a word memory.
// Define AXI_WRAP_BURST_EN to support WRAP bursts; otherwise WRAP is rejected like a reserved burst.
module axi_write_slave #(
    parameter int WIDTH     = 32,
    parameter int SIZE      = 3,
    parameter int MEM_WORDS = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH/8-1:0]           AWID,
    input  logic [WIDTH-1:0]             AWADDR,
    input  logic [WIDTH/8-1:0]           AWLEN,
    input  logic [SIZE-1:0]              AWSIZE,
    input  logic [SIZE-2:0]              AWBURST,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [WIDTH/8-1:0]           WID,
    input  logic [WIDTH-1:0]             WDATA,
    input  logic [WIDTH/8-1:0]           WSTRB,
    input  logic                         WLAST,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [WIDTH/8-1:0]           BID,
    output logic [SIZE-2:0]              BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
    output logic [WIDTH-1:0]             dbg_data
);
    localparam int IW = WIDTH / 8;
    localparam int BW = SIZE - 1;
    localparam int AW = $clog2(MEM_WORDS);
    localparam int LB = $clog2(WIDTH / 8);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    id_q, id_d, len_q, len_d, cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [SIZE-1:0]  size_q, size_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic             err_q, err_d, skip_q, skip_d;
    logic             awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [WIDTH-1:0] mem [MEM_WORDS];

    logic             aw_hs, w_hs, b_hs, last, in_range, we, beat_err, aw_bad, wrap_bad;
    logic [WIDTH-1:0] step, wmask, incr, next_addr, widx;

    assign aw_hs     = awready_q & AWVALID;
    assign w_hs      = wready_q & WVALID;
    assign b_hs      = bvalid_q & BREADY;
    assign step      = WIDTH'(1) << size_q;
    assign wmask     = step * (WIDTH'(len_q) + WIDTH'(1)) - WIDTH'(1);
    assign incr      = addr_q + step;
    assign next_addr = burst_q == BW'(0) ? addr_q :
                       burst_q == BW'(2) ? (addr_q & ~wmask) | (incr & wmask) : incr;
    assign widx      = addr_q >> LB;
    assign in_range  = widx < WIDTH'(MEM_WORDS);
    assign last      = cnt_q == len_q;
    assign we        = w_hs & ~skip_q & in_range;
    assign beat_err  = ~in_range | (WID != id_q) | (WLAST != last);
`ifdef AXI_WRAP_BURST_EN
    assign wrap_bad  = AWBURST == BW'(2) &&
                       (!(AWLEN == IW'(1) || AWLEN == IW'(3) || AWLEN == IW'(7) || AWLEN == IW'(15)) ||
                        (AWADDR & ((WIDTH'(1) << AWSIZE) - WIDTH'(1))) != '0);
`else
    assign wrap_bad  = AWBURST == BW'(2);
`endif
    assign aw_bad    = (AWSIZE > SIZE'(LB)) | (AWBURST == BW'(3)) | wrap_bad;

    assign AWREADY  = awready_q;
    assign WREADY   = wready_q;
    assign BVALID   = bvalid_q;
    assign BID      = id_q;
    assign BRESP    = {err_q, {(BW-1){1'b0}}};
    assign dbg_data = mem[dbg_addr];

    // Next-state: capture burst on AW, advance address/count per beat, release on B.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        skip_d  = skip_q;
        if (aw_hs) begin
            state_d = DATA;
            id_d    = AWID;
            addr_d  = AWADDR;
            len_d   = AWLEN;
            size_d  = AWSIZE;
            burst_d = AWBURST;
            cnt_d   = '0;
            err_d   = aw_bad;
            skip_d  = aw_bad;
        end
        if (w_hs) begin
            cnt_d   = cnt_q + IW'(1);
            addr_d  = next_addr;
            err_d   = err_q | beat_err;
            state_d = last ? RESP : DATA;
        end
        if (b_hs) state_d = IDLE;
        awready_d = state_d == IDLE;
        wready_d  = state_d == DATA;
        bvalid_d  = state_d == RESP;
    end

    // Control state and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            skip_q    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            skip_q    <= skip_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    // Byte-lane memory commit; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IW; i++)
            if (we && WSTRB[i]) mem[widx[AW-1:0]][8*i +: 8] <= WDATA[8*i +: 8];
    end
endmodule
